// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;
  localparam logic [1:0] WB_NOP = 2'b00;

  typedef enum logic [1:0] {
    Run,
    MemWait,
    Halt
  } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. master = pipeline side, slave = controller.
interface hazard_ctrl_if;
  import hazard_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rt;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_write;
  logic idex_flush;
  logic exmem_write;
  logic memwb_bubble;
  logic mem_err;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, branch_taken, mem_req, mem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write,
           memwb_bubble, mem_err
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, branch_taken, mem_req, mem_ready,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write,
           memwb_bubble, mem_err
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX writes a register the ID instruction reads.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  output logic             hit
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt == id_rs);
  assign rt_match = id_uses_rt && (ex_rt == id_rt);

  // $zero is never really written, so it can never create a dependency.
  assign hit = ex_memread && (ex_rt != ZERO_REG) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencer: memory-wait freeze, branch flush, load-use bubble, timeout halt.
// Optional HAZ_STATS_EN adds saturating stall/flush statistics counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
`ifdef HAZ_STATS_EN
  ,
  parameter int unsigned STAT_W  = 32
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_ctrl_if.slave       bus
`ifdef HAZ_STATS_EN
  ,
  output logic [STAT_W-1:0]  stall_cnt,
  output logic [STAT_W-1:0]  flush_cnt
`endif
);

  localparam logic [CNT_W:0] TimeoutLim = (CNT_W + 1)'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W:0]   wait_inc;
  logic             mem_err_q, mem_err_d;
  logic             lu_hit;
  logic             freeze;
  logic             run_like;

  load_use_detect u_load_use_detect (
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_uses_rt (bus.id_uses_rt),
    .ex_memread (bus.ex_memread),
    .ex_rt      (bus.ex_rt),
    .hit        (lu_hit)
  );

  assign wait_inc = {1'b0, wait_cnt_q} + (CNT_W + 1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= Run;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    freeze     = 1'b0;
    run_like   = 1'b0;

    unique case (state_q)
      Run: begin
        if (bus.mem_req && !bus.mem_ready) begin
          freeze     = 1'b1;
          state_d    = MemWait;
          wait_cnt_d = CNT_W'(1);
        end else begin
          run_like = 1'b1;
        end
      end
      MemWait: begin
        if (bus.mem_ready) begin
          // Completion cycle behaves like Run so a branch held during the freeze is honoured.
          run_like   = 1'b1;
          state_d    = Run;
          wait_cnt_d = '0;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_inc[CNT_W-1:0];
          if (wait_inc >= TimeoutLim) begin
            mem_err_d = 1'b1;
            state_d   = Halt;
          end
        end
      end
      Halt: begin
        freeze = 1'b1;
      end
      default: begin
        freeze  = 1'b1;
        state_d = Run;
      end
    endcase
  end

  always_comb begin
    bus.pc_write     = 1'b1;
    bus.ifid_write   = 1'b1;
    bus.ifid_flush   = 1'b0;
    bus.idex_write   = 1'b1;
    bus.idex_flush   = 1'b0;
    bus.exmem_write  = 1'b1;
    bus.memwb_bubble = 1'b0;
    bus.mem_err      = mem_err_q;

    if (!rst_n) begin
      bus.pc_write     = 1'b0;
      bus.ifid_write   = 1'b0;
      bus.idex_write   = 1'b0;
      bus.exmem_write  = 1'b0;
      bus.ifid_flush   = 1'b1;
      bus.idex_flush   = 1'b1;
      bus.memwb_bubble = 1'b1;
    end else if (freeze) begin
      bus.pc_write     = 1'b0;
      bus.ifid_write   = 1'b0;
      bus.idex_write   = 1'b0;
      bus.exmem_write  = 1'b0;
      bus.memwb_bubble = 1'b1;
    end else if (run_like && bus.branch_taken) begin
      // The dependent instruction is flushed, so any load-use hit is moot.
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (run_like && lu_hit) begin
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
      bus.idex_flush = 1'b1;
    end
  end

`ifdef HAZ_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic              stall_evt, flush_evt;

  assign stall_evt = rst_n && (state_q != Halt) && !bus.pc_write;
  assign flush_evt = rst_n && run_like && bus.branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + STAT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
